// File: rtl/cache_line_mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_line_mem_master                                      |
// | Description : Line-granular initiator for a word-wide memory bank.       |
// |               Serialises writebacks and assembles fills one word at a    |
// |               time, with a per-word timeout abort.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cache_line_mem_master #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT        = 15
) (
  input  logic                                           clock_i,
  input  logic                                           reset_i,
  input  logic                                           req_valid_i,
  output logic                                           req_ready_o,
  input  logic [1:0]                                     req_op_i,
  input  logic [ADDR_WIDTH-$clog2(WORDS_PER_LINE)-1:0]   req_fill_addr_i,
  input  logic [ADDR_WIDTH-$clog2(WORDS_PER_LINE)-1:0]   req_wb_addr_i,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0]            req_wdata_i,
  output logic                                           resp_valid_o,
  output logic                                           resp_error_o,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0]            resp_rdata_o,
  output logic                                           busy_o,
  output logic                                           mem_rd_o,
  output logic                                           mem_wr_o,
  output logic [ADDR_WIDTH-1:0]                          mem_addr_o,
  output logic [WORD_SIZE-1:0]                           mem_wdata_o,
  input  logic [WORD_SIZE-1:0]                           mem_rdata_i,
  input  logic                                           mem_ready_i
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_WIDTH - OFF_W;
  localparam int DATA_W = WORD_SIZE * WORDS_PER_LINE;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WB_ISSUE = 3'd1,
    S_WB_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q;
  logic [OFF_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fill_after_wb_q;
  logic [LINE_W-1:0]   fill_addr_q;
  logic [LINE_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_error_q;
  logic                busy_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0]  mem_wdata_q;

  logic [OFF_W-1:0]     idx_inc_d;
  logic [WORD_SIZE-1:0] wb_next_word_d;

  // Next word index and the victim word that goes with it.
  always_comb begin
    idx_inc_d      = idx_q + OFF_W'(1);
    wb_next_word_d = wdata_q[int'(idx_inc_d)*WORD_SIZE +: WORD_SIZE];
  end

  // Request sequencing FSM; every output is registered alongside the state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      fill_after_wb_q <= 1'b0;
      fill_addr_q     <= '0;
      wb_addr_q       <= '0;
      wdata_q         <= '0;
      resp_rdata_q    <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_error_q    <= 1'b0;
      busy_q          <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      // Strobes and the completion pulse last a single cycle.
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Op 00 is not a request; it is never accepted.
          if (req_valid_i && (req_op_i != 2'b00)) begin
            fill_after_wb_q <= req_op_i[0];
            fill_addr_q     <= req_fill_addr_i;
            wb_addr_q       <= req_wb_addr_i;
            wdata_q         <= req_wdata_i;
            idx_q           <= '0;
            req_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            if (req_op_i[1]) begin
              state_q     <= S_WB_ISSUE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {req_wb_addr_i, {OFF_W{1'b0}}};
              mem_wdata_q <= req_wdata_i[WORD_SIZE-1:0];
            end else begin
              state_q    <= S_RD_ISSUE;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {req_fill_addr_i, {OFF_W{1'b0}}};
            end
          end
        end
        S_WB_ISSUE: begin
          state_q <= S_WB_WAIT;
          cnt_q   <= '0;
        end
        S_WB_WAIT: begin
          if (mem_ready_i) begin
            if (idx_q == LAST_IDX) begin
              if (fill_after_wb_q) begin
                state_q    <= S_RD_ISSUE;
                idx_q      <= '0;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {fill_addr_q, {OFF_W{1'b0}}};
              end else begin
                state_q      <= S_DONE;
                resp_valid_q <= 1'b1;
              end
            end else begin
              state_q     <= S_WB_ISSUE;
              idx_q       <= idx_inc_d;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {wb_addr_q, idx_inc_d};
              mem_wdata_q <= wb_next_word_d;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RD_ISSUE: begin
          state_q <= S_RD_WAIT;
          cnt_q   <= '0;
        end
        S_RD_WAIT: begin
          if (mem_ready_i) begin
            resp_rdata_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] <= mem_rdata_i;
            if (idx_q == LAST_IDX) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
            end else begin
              state_q    <= S_RD_ISSUE;
              idx_q      <= idx_inc_d;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {fill_addr_q, idx_inc_d};
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_error_o = resp_error_q;
  assign resp_rdata_o = resp_rdata_q;
  assign busy_o       = busy_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cache_line_mem_master                                   |
// | Description : Self-checking bench: zero-wait memory stub, line-level     |
// |               reference model, directed and randomized requests.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cache_line_mem_master;

  localparam int W      = 32;
  localparam int AW     = 8;
  localparam int WPL    = 4;
  localparam int OFF_W  = 2;
  localparam int LW     = AW - OFF_W;
  localparam int DW     = W * WPL;
  localparam int TMO    = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [LW-1:0] req_fill_addr = '0;
  logic [LW-1:0] req_wb_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_error;
  logic [DW-1:0] resp_rdata;
  logic          busy;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;

  cache_line_mem_master #(
    .WORD_SIZE(W), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .TIMEOUT(TMO)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_fill_addr_i(req_fill_addr), .req_wb_addr_i(req_wb_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_error_o(resp_error), .resp_rdata_o(resp_rdata),
    .busy_o(busy), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge equals the index of the preceding posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stub: ready one cycle after a strobe, old data returned on writes.
  logic [W-1:0] mem [0:(1<<AW)-1];
  bit ready_en = 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= W'(i);
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= (mem_rd || mem_wr) && ready_en;
      if (mem_rd || mem_wr) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    int           cyc;
    bit           rd;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } strobe_t;

  strobe_t strobe_q[$];
  always @(negedge clk) begin
    if (mem_rd || mem_wr) strobe_q.push_back('{cyc, mem_rd, mem_addr, mem_wdata});
  end

  // Reference state
  logic [W-1:0]  ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rdata = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = W'(i);
    exp_rdata = '0;
  endtask

  // One line request; expectations are derived from line-level rules.
  task automatic run_req(input logic [1:0] op, input logic [LW-1:0] fill,
                         input logic [LW-1:0] wb, input logic [DW-1:0] wd,
                         input bit timeout, input bit hold_busy);
    strobe_t exp_q[$];
    int a;
    int t;
    int rc;
    int lat;
    @(negedge clk);
    check("req_ready_idle", {127'd0, req_ready}, 128'd1);
    strobe_q.delete();
    req_valid = 1'b1; req_op = op; req_fill_addr = fill; req_wb_addr = wb; req_wdata = wd;
    @(negedge clk);
    a = cyc;
    if (hold_busy) begin
      req_op = 2'b01;
      req_fill_addr = ~fill;
    end else begin
      req_valid = 1'b0;
    end
    // Expected strobe schedule: one word every two cycles, index 0 ascending.
    t = a;
    if (op[1]) begin
      for (int i = 0; i < WPL; i++) begin
        exp_q.push_back('{t, 1'b0, {wb, OFF_W'(i)}, wd[i*W +: W]});
        ref_mem[{wb, OFF_W'(i)}] = wd[i*W +: W];
        t += 2;
        if (timeout) break;
      end
    end
    if (op[0] && !(timeout && op[1])) begin
      for (int i = 0; i < WPL; i++) begin
        exp_q.push_back('{t, 1'b1, {fill, OFF_W'(i)}, '0});
        if (!timeout) exp_rdata[i*W +: W] = ref_mem[{fill, OFF_W'(i)}];
        t += 2;
        if (timeout) break;
      end
    end
    lat = timeout ? 1 + TMO : t - a;
    rc = -1;
    for (int k = 0; k < 200; k++) begin
      check("rd_wr_exclusive", {127'd0, mem_rd && mem_wr}, 128'd0);
      if (hold_busy) check("req_ready_busy", {127'd0, req_ready}, 128'd0);
      if (resp_valid) begin
        rc = cyc;
        req_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("resp_cycle", 128'(rc - a), 128'(lat));
    check("resp_error", {127'd0, resp_error}, {127'd0, timeout});
    check("resp_rdata", resp_rdata, exp_rdata);
    @(negedge clk);
    check("resp_pulse", {127'd0, resp_valid}, 128'd0);
    check("idle_state", {126'd0, busy, req_ready}, 128'd1);
    check("strobe_count", 128'(strobe_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++) begin
      check("strobe_cyc", 128'(strobe_q[i].cyc - a), 128'(exp_q[i].cyc - a));
      check("strobe_kind", {127'd0, strobe_q[i].rd}, {127'd0, exp_q[i].rd});
      check("strobe_addr", 128'(strobe_q[i].addr), 128'(exp_q[i].addr));
      if (!exp_q[i].rd) check("strobe_wdata", 128'(strobe_q[i].wdata), 128'(exp_q[i].wdata));
    end
    if (hold_busy) begin
      repeat (3) @(negedge clk);
      check("no_queued_req", {126'd0, busy, resp_valid}, 128'd0);
      check("no_extra_strobe", 128'(strobe_q.size()), 128'(exp_q.size()));
    end
  endtask

  initial begin
    logic [DW-1:0] wd;
    int a;
    int diff;
    ref_reset();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ready", {127'd0, req_ready}, 128'd1);
    check("rst_outputs", {124'd0, busy, mem_rd, mem_wr, resp_valid}, 128'd0);
    check("rst_rdata", resp_rdata, '0);
    check("rst_addr", 128'(mem_addr), 128'd0);
    rst = 1'b0;

    // Directed requests
    run_req(2'b01, 6'd3, 6'd0, '0, 1'b0, 1'b0);
    check("fill3_data", resp_rdata, {32'd15, 32'd14, 32'd13, 32'd12});
    wd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_req(2'b10, 6'd0, 6'd5, wd, 1'b0, 1'b0);
    run_req(2'b01, 6'd5, 6'd0, '0, 1'b0, 1'b0);
    check("fill5_data", resp_rdata, wd);
    wd = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    run_req(2'b11, 6'd7, 6'd2, wd, 1'b0, 1'b0);
    check("wbfill_data", resp_rdata, {32'd31, 32'd30, 32'd29, 32'd28});

    // Memory never answers: abort after the timeout, earlier data kept
    ready_en = 1'b0;
    run_req(2'b01, 6'd9, 6'd0, '0, 1'b1, 1'b0);
    ready_en = 1'b1;
    repeat (2) @(negedge clk);

    // Request held while busy is neither accepted nor queued
    run_req(2'b01, 6'd12, 6'd0, '0, 1'b0, 1'b1);

    // Illegal op in IDLE
    @(negedge clk);
    strobe_q.delete();
    req_valid = 1'b1; req_op = 2'b00;
    repeat (4) begin
      @(negedge clk);
      check("illegal_busy", {127'd0, busy}, 128'd0);
    end
    req_valid = 1'b0;
    check("illegal_strobes", 128'(strobe_q.size()), 128'd0);

    // Reset in the middle of a fill
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_fill_addr = 6'd20;
    @(negedge clk);
    a = cyc;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_pre_rd", {127'd0, mem_rd}, 128'd1);
    rst = 1'b1;
    #1;
    check("rstmid_outputs", {125'd0, mem_rd, busy, resp_valid}, 128'd0);
    check("rstmid_ready", {127'd0, req_ready}, 128'd1);
    check("rstmid_rdata", resp_rdata, '0);
    ref_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_resp", {127'd0, resp_valid}, 128'd0);
    end
    run_req(2'b01, 6'd20, 6'd0, '0, 1'b0, 1'b0);

    // Randomized requests against the reference model
    for (int n = 0; n < 24; n++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      run_req(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)),
              6'($urandom_range(0, 63)), wd, 1'b0, 1'b0);
    end

    // Final memory image
    @(negedge clk);
    diff = 0;
    for (int i = 0; i < (1<<AW); i++) if (mem[i] !== ref_mem[i]) diff++;
    check("mem_image", 128'(diff), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/cache_line_mem_master.md
Name: cache_line_mem_master

Overview:
- Initiator side of the word-wide memory bank interface (rd/wr/addr/data_in/data_out/data_ready) for the 4-way set-associative cache.
- Takes line-granular requests from the cache controller: fill, writeback, or writeback-then-fill for a dirty eviction.
- Turns each request into a sequence of single-word memory accesses and assembles or serialises the cache line.
- Returns one completion pulse per request.

Parameters:
WORD_SIZE, 32, memory word width in bits
ADDR_WIDTH, 8, memory word address width
WORDS_PER_LINE, 4, words per cache line (power of 2, >=2); OFF_W = log2(WORDS_PER_LINE)
TIMEOUT, 15, max cycles spent in WAIT for mem_ready before aborting

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready at a rising edge
req_op  in  2  01=fill, 10=writeback, 11=writeback then fill, 00=illegal (ignored, not accepted)
req_fill_addr  in  ADDR_WIDTH-OFF_W  line address to fill
req_wb_addr  in  ADDR_WIDTH-OFF_W  victim line address to write back
req_wdata  in  WORD_SIZE*WORDS_PER_LINE  victim line; word i at [i*WORD_SIZE +: WORD_SIZE]
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  valid with resp_valid; 1 = timeout abort
resp_rdata  out  WORD_SIZE*WORDS_PER_LINE  filled line, same packing as req_wdata; held until next fill capture
busy  out  1  high in every state except IDLE
mem_rd  out  1  to memory rd
mem_wr  out  1  to memory wr
mem_addr  out  ADDR_WIDTH  {line_addr, word_idx}
mem_wdata  out  WORD_SIZE  to memory data_in
mem_rdata  in  WORD_SIZE  from memory data_out
mem_ready  in  1  from memory data_ready

Behaviour:
- Reset, asynchronous: all outputs 0 except req_ready=1; resp_rdata=0; FSM=IDLE; word index and timeout counter 0; latched request cleared.
- FSM states: IDLE, WB_ISSUE, WB_WAIT, RD_ISSUE, RD_WAIT, DONE.
- On accept:
  - latch op, both addresses and req_wdata.
  - Op 10 or 11 go to WB_ISSUE; op 01 goes to RD_ISSUE; word index = 0.
- WB_ISSUE (1 cycle):
  - mem_wr=1, mem_addr={wb_addr,idx}, mem_wdata=word idx of latched line.
  - Next state WB_WAIT.
- WB_WAIT:
  - mem_wr=0, mem_rd=0; mem_addr and mem_wdata hold.
  - On mem_ready=1: if idx is last, go to RD_ISSUE with idx=0 (op 11) or to DONE (op 10); otherwise idx+1 and go to WB_ISSUE.
- RD_ISSUE (1 cycle): mem_rd=1, mem_addr={fill_addr,idx}; next state RD_WAIT.
- RD_WAIT:
  - On mem_ready=1: capture mem_rdata into resp_rdata word idx.
  - If idx is last, go to DONE; otherwise idx+1 and go to RD_ISSUE.
- DONE: resp_valid=1 for exactly one cycle, resp_error=0; next state IDLE.
- mem_rd/mem_wr are single-cycle pulses per word and are never both high.
  - The memory answers with data_ready one cycle after the strobe and drops it the cycle after the strobe falls, so each word takes exactly 2 cycles against a zero-wait memory.
- mem_ready sampled only in *_WAIT; ignored in all other states.
- mem_rdata is ignored during writeback (the memory returns old data on wr).
- Latency, zero-wait memory, accept at edge 0:
  - fill: resp_valid high in cycle 2*WORDS_PER_LINE+1 (cycle 9 at default).
  - writeback: cycle 9.
  - writeback then fill: cycle 17.
- Timeout:
  - Counter clears on entering each *_WAIT and increments every WAIT cycle without mem_ready.
  - When it reaches TIMEOUT with no ready: resp_valid=1, resp_error=1 for one cycle, then IDLE.
  - resp_rdata words captured before the abort are kept; the rest are unchanged.
  - Remaining words are not issued.
- Request while busy is not accepted; req_ready stays 0, and nothing is queued.
- Back-to-back: a new request can be accepted the cycle after DONE (IDLE cycle).
- Reset mid-operation aborts immediately: mem_rd/mem_wr drop to 0 in the same instant, no resp_valid.
- Partially written lines remain in memory as written; no recovery.
- Word order is always index 0 ascending; mem_addr wraps only within the line (no carry into the line address).

Test Plan:
- Reset, then fill line 3 against a memory initialised to data[i]=i: mem_rd pulses at addrs 12,13,14,15 in cycles 1,3,5,7; resp_valid in cycle 9; resp_rdata={15,14,13,12}; resp_error=0.
- Writeback line 5 with words 0xA0..0xA3, then fill line 5: mem_wr at addrs 20..23 with mem_wdata 0xA0..0xA3; resp at cycle 9; subsequent fill returns {0xA3,0xA2,0xA1,0xA0}.
- Op 11, wb_addr=2, fill_addr=7, wdata=0xB0..0xB3: writes to addrs 8..11, then reads of 28..31; single resp_valid at cycle 17; rdata={31,30,29,28}; memory[8..11]=0xB0..0xB3.
- Memory stub that never asserts mem_ready during a fill: after one mem_rd, resp_valid=1 and resp_error=1 exactly 15 WAIT cycles later; FSM returns to IDLE; no further mem_rd.
- req_valid held high with op 01 during an active fill, plus op 00 presented in IDLE: neither is accepted (req_ready=0 / no mem activity); only the original resp_valid appears.
- Assert reset in cycle 4 of a fill: mem_rd=0, busy=0, req_ready=1 immediately; no resp_valid; a fill after release completes normally at cycle 9.
